// File: rtl/my_project_pkg.sv
// Shared types, fixed-point constants and the trained weight set for the
// 2-4-1 MLP inference core.
package my_project_pkg;

   localparam int DATA_W   = 18;
   localparam int FRAC_W   = 10;
   localparam int N_HIDDEN = 4;
   localparam int N_INPUTS = 2;
   localparam int PROD_W   = 2 * DATA_W;
   localparam int ACC_W    = 40;

   typedef logic signed [DATA_W-1:0] fixed_t;
   typedef logic signed [PROD_W-1:0] prod_t;
   typedef logic signed [ACC_W-1:0]  acc_t;

   // Packed input word as delivered by the normalization stage.
   typedef struct packed {
      fixed_t x1;
      fixed_t x0;
   } in_word_t;

   // Q8.10 encodings of the real-valued weights.
   localparam fixed_t Q_ZERO    = 18'sd0;
   localparam fixed_t Q_ONE     = 18'sd1024;
   localparam fixed_t Q_HALF    = 18'sd512;
   localparam fixed_t Q_QUARTER = 18'sd256;
   localparam fixed_t Q_EIGHTH  = 18'sd128;

   localparam fixed_t W1 [N_HIDDEN][N_INPUTS] = '{
      '{ Q_ONE,   Q_ONE  },
      '{ Q_ONE,  -Q_ONE  },
      '{-Q_ONE,   Q_ONE  },
      '{ Q_HALF,  Q_HALF }
   };
   localparam fixed_t B1 [N_HIDDEN] = '{Q_ZERO, Q_ZERO, Q_ZERO, -Q_ONE};

   localparam fixed_t W2 [1][N_HIDDEN] = '{'{Q_HALF, Q_QUARTER, Q_QUARTER, -Q_ONE}};
   localparam fixed_t B2 [1] = '{Q_EIGHTH};

   localparam acc_t SAT_MAX = 40'sd131071;
   localparam acc_t SAT_MIN = -40'sd131072;

   // Drop the fraction bits (floor) and clamp into the activation range.
   function automatic fixed_t sat_shift(input acc_t acc);
      acc_t shifted;
      shifted = acc >>> FRAC_W;
      if (shifted > SAT_MAX) begin
         return fixed_t'(SAT_MAX);
      end else if (shifted < SAT_MIN) begin
         return fixed_t'(SAT_MIN);
      end
      return fixed_t'(shifted);
   endfunction

endpackage

// File: rtl/my_project_dense.sv
// Generic fully connected layer: exact multiply-accumulate, floor, saturate,
// optional ReLU, one register stage with a valid qualifier.
module my_project_dense
   import my_project_pkg::*;
#(
   parameter int     N_IN  = 2,
   parameter int     N_OUT = 4,
   parameter bit     RELU  = 1'b1,
   parameter fixed_t W [N_OUT][N_IN] = '{default: '{default: '0}},
   parameter fixed_t B [N_OUT]       = '{default: '0}
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   vld_i,
   input  fixed_t x_i [N_IN],
   output logic   vld_o,
   output fixed_t y_o [N_OUT]
);

   fixed_t y_d [N_OUT];
   fixed_t y_q [N_OUT];
   logic   vld_q;

   // Combinational dot products for every output neuron.
   always_comb begin
      acc_t  acc;
      prod_t prod;
      // NOTE: every variable gets a value before any branch so no latch is inferred.
      acc  = '0;
      prod = '0;
      for (int j = 0; j < N_OUT; j++) begin
         acc = acc_t'(B[j]) <<< FRAC_W;
         for (int i = 0; i < N_IN; i++) begin
            prod = W[j][i] * x_i[i];
            acc  = acc + acc_t'(prod);
         end
         y_d[j] = sat_shift(acc);
         if (RELU && y_d[j][DATA_W-1]) begin
            y_d[j] = '0;
         end
      end
   end

   // Pipeline register; data only moves with a valid sample so it holds otherwise.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         vld_q <= 1'b0;
         y_q   <= '{default: '0};
      end else begin
         vld_q <= vld_i;
         if (vld_i) begin
            y_q <= y_d;
         end
      end
   end

   assign vld_o = vld_q;
   assign y_o   = y_q;

endmodule

// File: rtl/my_project.sv
// 2-input, 1-output MLP inference core: input register, hidden layer with
// ReLU, linear output layer. II = 1, latency 3, ap_ctrl_hs-style handshake.
module my_project
   import my_project_pkg::*;
(
   input  logic                   ap_clk,
   input  logic                   ap_rst,
   input  logic                   ap_start,
   output logic                   ap_done,
   output logic                   ap_idle,
   output logic                   ap_ready,
   input  logic                   input_2_V_ap_vld,
   input  logic [2*DATA_W-1:0]    input_2_V,
   output logic [DATA_W-1:0]      layer7_out_0_V,
   output logic                   layer7_out_0_V_ap_vld
);

   in_word_t in_word;
   logic     accept;

   fixed_t   x_q [N_INPUTS];
   logic     x_vld_q;

   fixed_t   h [N_HIDDEN];
   logic     h_vld;
   fixed_t   y [1];
   logic     y_vld;

   assign in_word = in_word_t'(input_2_V);
   assign accept  = ap_start & input_2_V_ap_vld;

   // Stage 1 valid bit; cleared by reset so in-flight samples are discarded.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         x_vld_q <= 1'b0;
      end else begin
         x_vld_q <= accept;
      end
   end

   // Stage 1 data capture on accepted samples.
   always_ff @(posedge ap_clk) begin
      // NOTE: data registers need no reset here; downstream only uses them under x_vld_q.
      if (accept) begin
         x_q[0] <= in_word.x0;
         x_q[1] <= in_word.x1;
      end
   end

   my_project_dense #(
      .N_IN  (N_INPUTS),
      .N_OUT (N_HIDDEN),
      .RELU  (1'b1),
      .W     (W1),
      .B     (B1)
   ) u_hidden (
      .clk   (ap_clk),
      .rst   (ap_rst),
      .vld_i (x_vld_q),
      .x_i   (x_q),
      .vld_o (h_vld),
      .y_o   (h)
   );

   my_project_dense #(
      .N_IN  (N_HIDDEN),
      .N_OUT (1),
      .RELU  (1'b0),
      .W     (W2),
      .B     (B2)
   ) u_output (
      .clk   (ap_clk),
      .rst   (ap_rst),
      .vld_i (h_vld),
      .x_i   (h),
      .vld_o (y_vld),
      .y_o   (y)
   );

   assign ap_ready              = accept;
   assign ap_done               = y_vld;
   assign layer7_out_0_V_ap_vld = y_vld;
   assign layer7_out_0_V        = y[0];
   assign ap_idle               = ~ap_start & ~(x_vld_q | h_vld | y_vld);

endmodule

// File: tb/tb_my_project.sv
// Self-checking bench for my_project: vector table plus scoreboard of
// expected results with their due cycle, and hand-written corner sequences.
module tb_my_project;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic        ap_start;
   logic        ap_done;
   logic        ap_idle;
   logic        ap_ready;
   logic        input_2_V_ap_vld;
   logic [35:0] input_2_V;
   logic [17:0] layer7_out_0_V;
   logic        layer7_out_0_V_ap_vld;

   my_project dut (
      .ap_clk                (ap_clk),
      .ap_rst                (ap_rst),
      .ap_start              (ap_start),
      .ap_done               (ap_done),
      .ap_idle               (ap_idle),
      .ap_ready              (ap_ready),
      .input_2_V_ap_vld      (input_2_V_ap_vld),
      .input_2_V             (input_2_V),
      .layer7_out_0_V        (layer7_out_0_V),
      .layer7_out_0_V_ap_vld (layer7_out_0_V_ap_vld)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct {
      logic [17:0] x0;
      logic [17:0] x1;
      logic [17:0] y;
   } vec_t;

   typedef struct {
      logic [17:0] y;
      int          due;
   } exp_t;

   exp_t sb [$];
   vec_t vecs [8];

   int cyc       = 0;
   int n_checks  = 0;
   int n_pass    = 0;
   int vld_seen  = 0;

   always @(posedge ap_clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act == req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d) at cycle %0d",
                  name, act, act, req, req, cyc);
      end
   endtask

   // One cycle of stimulus, applied just after the rising edge.
   task automatic drive(input logic st, input logic vl, input logic [17:0] x0,
                        input logic [17:0] x1, input logic [17:0] y, input bit expect_out);
      @(posedge ap_clk);
      #1;
      ap_start         = st;
      input_2_V_ap_vld = vl;
      input_2_V        = {x1, x0};
      #1;
      check("ap_ready", ap_ready, st & vl);
      if (st && vl && expect_out) begin
         sb.push_back('{y: y, due: cyc + 3});
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 1'b0, 18'h0, 18'h0, 18'h0, 1'b0);
      end
   endtask

   // Output monitor: every valid pulse must match the head of the scoreboard,
   // on the cycle it was due.
   always @(negedge ap_clk) begin
      if (layer7_out_0_V_ap_vld) begin
         vld_seen++;
         if (sb.size() == 0) begin
            check("unexpected_vld", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("y_out", layer7_out_0_V, e.y);
            check("latency", cyc, e.due);
            check("ap_done", ap_done, 1);
         end
      end
   end

   initial begin
      int seen_before;

      vecs[0] = '{x0: 18'h00000, x1: 18'h00000, y: 18'd128};
      vecs[1] = '{x0: 18'h00800, x1: 18'h00400, y: 18'd1408};
      vecs[2] = '{x0: 18'h3FC00, x1: 18'h00000, y: 18'd384};
      vecs[3] = '{x0: 18'h1FFFF, x1: 18'h1FFFF, y: 18'h30480};
      vecs[4] = '{x0: 18'h00400, x1: 18'h00400, y: 18'd1152};
      vecs[5] = '{x0: 18'h00000, x1: 18'h00800, y: 18'd1664};
      vecs[6] = '{x0: 18'h20000, x1: 18'h20000, y: 18'd128};
      vecs[7] = '{x0: 18'h1FFFF, x1: 18'h00000, y: 18'd33920};

      // Reset with a valid request pending: nothing may be accepted or emitted.
      ap_rst           = 1'b1;
      ap_start         = 1'b0;
      input_2_V_ap_vld = 1'b0;
      input_2_V        = '0;
      repeat (2) @(posedge ap_clk);
      #1;
      ap_start         = 1'b1;
      input_2_V_ap_vld = 1'b1;
      repeat (3) @(posedge ap_clk);
      #1;
      check("rst_out", layer7_out_0_V, 0);
      check("rst_vld", layer7_out_0_V_ap_vld, 0);
      check("rst_done", ap_done, 0);
      check("rst_idle_start1", ap_idle, 0);
      ap_start = 1'b0;
      #1;
      check("rst_idle_start0", ap_idle, 1);
      check("rst_ready_start0", ap_ready, 0);
      check("rst_no_vld", vld_seen, 0);
      @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;
      input_2_V_ap_vld = 1'b0;
      idle_cycles(2);
      check("post_rst_no_vld", vld_seen, 0);

      // Table vectors back to back, one per cycle.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b1, vecs[i].x0, vecs[i].x1, vecs[i].y, 1'b1);
      end
      idle_cycles(5);
      check("table_drained", sb.size(), 0);
      check("hold_last", layer7_out_0_V, vecs[7].y);
      check("idle_empty", ap_idle, 1);

      // One-cycle gap in the input valid must reappear as a gap in the output.
      drive(1'b1, 1'b1, vecs[0].x0, vecs[0].x1, vecs[0].y, 1'b1);
      drive(1'b1, 1'b0, vecs[3].x0, vecs[3].x1, vecs[3].y, 1'b1);
      drive(1'b1, 1'b1, vecs[1].x0, vecs[1].x1, vecs[1].y, 1'b1);
      drive(1'b1, 1'b1, vecs[2].x0, vecs[2].x1, vecs[2].y, 1'b1);
      check("busy_not_idle", ap_idle, 0);
      drive(1'b1, 1'b0, 18'h0, 18'h0, 18'h0, 1'b0);
      check("start_novld_idle", ap_idle, 0);
      idle_cycles(5);
      check("gap_drained", sb.size(), 0);

      // Reset while two samples are in flight: both are discarded.
      seen_before = vld_seen;
      drive(1'b1, 1'b1, vecs[1].x0, vecs[1].x1, vecs[1].y, 1'b0);
      drive(1'b1, 1'b1, vecs[3].x0, vecs[3].x1, vecs[3].y, 1'b0);
      @(posedge ap_clk);
      #1;
      ap_start         = 1'b0;
      input_2_V_ap_vld = 1'b0;
      ap_rst           = 1'b1;
      @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;
      check("midrst_out_zero", layer7_out_0_V, 0);
      idle_cycles(5);
      check("midrst_discard", vld_seen, seen_before);
      check("midrst_idle", ap_idle, 1);

      // Pipeline still works after the mid-flight reset.
      drive(1'b1, 1'b1, vecs[5].x0, vecs[5].x1, vecs[5].y, 1'b1);
      idle_cycles(5);
      check("final_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/my_project.md
Name: my_project

Overview:
- Fixed-point 2-input, 1-output multilayer perceptron inference core.
- Sits downstream of the input normalization stage, which packs two normalized samples into one 36-bit word every cycle.
- Network: dense(2→4) + ReLU, then dense(4→1), linear.
- Fully pipelined, initiation interval 1, fixed latency, with ap_ctrl_hs-style control plus ap_vld data qualifiers.

Parameters:
- DATA_W, 18, width of every activation, weight and bias (signed Q8.10: 8 integer bits including sign, 10 fraction bits).
- FRAC_W, 10, fraction bits of DATA_W.
- N_HIDDEN, 4, hidden neuron count. The weight set is defined for 4.
- LATENCY, 3, cycles from accepted input to output valid.

Ports:
- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst  in  1  reset; synchronous, active-high.
- ap_start  in  1  enable; an input is accepted only while high.
- ap_done  out  1  equals layer7_out_0_V_ap_vld.
- ap_idle  out  1  high when ap_start is low and no sample is in flight.
- ap_ready  out  1  combinational; equals ap_start & input_2_V_ap_vld (input accepted this cycle).
- input_2_V_ap_vld  in  1  input word valid.
- input_2_V  in  36  packed inputs: x0 = [17:0], x1 = [35:18], both Q8.10 signed.
- layer7_out_0_V  out  18  network output, Q8.10 signed.
- layer7_out_0_V_ap_vld  out  1  one-cycle pulse per result.

Behaviour:
- Reset:
  - All pipeline valid bits are 0.
  - layer7_out_0_V = 0, layer7_out_0_V_ap_vld = 0, ap_done = 0.
  - ap_idle = !ap_start.
  - A sample in flight when reset asserts is discarded and produces no output.
- Accept:
  - At an edge where ap_start & input_2_V_ap_vld is high, x0 and x1 are registered (stage 1).
  - A new sample may be accepted every cycle.
- Stage 2 (hidden layer):
  - acc_j = sum_i W1[j][i]*x_i + (b1[j] << FRAC_W), computed exactly: 36-bit Q16.20 products, 40-bit signed accumulator.
  - h_j = acc_j >>> FRAC_W (floor), then saturate to the 18-bit signed range, then ReLU (negative becomes 0).
  - h_j is registered.
- Stage 3 (output layer):
  - y = sum_j W2[j]*h_j + (b2 << FRAC_W), with the same width, floor and saturation rules and no activation.
  - y is registered into layer7_out_0_V, and layer7_out_0_V_ap_vld is raised for exactly one cycle.
- Timing: for a sample accepted at edge k, the output is valid in the cycle after edge k+2 (LATENCY = 3 register stages).
- layer7_out_0_V holds its last value while the valid flag is low.
- Weights are Q8.10 constants, written here as real values:
  - W1 rows: (1, 1), (1, −1), (−1, 1), (0.5, 0.5).
  - b1 = (0, 0, 0, −1).
  - W2 = (0.5, 0.25, 0.25, −1).
  - b2 = 0.125.
- Saturation bounds: +131071 (0x1FFFF) and −131072.
- Gaps in input_2_V_ap_vld propagate as gaps in the output valid; the order of results is preserved.

Decomposition:
- Package my_project_pkg holds:
  - the DATA_W/FRAC_W/N_HIDDEN constants;
  - the fixed_t typedef (signed [17:0]) and the acc_t typedef (signed [39:0]);
  - the W1, b1, W2 and b2 constant arrays;
  - a saturate-and-shift function.
- One sub-module is natural: my_project_dense (generic N_IN×N_OUT multiply-accumulate with optional ReLU, one register stage). It is instantiated twice.

Test Plan:
- Reset, then ap_start=1 with input_2_V=0 and vld=1 → after 3 cycles, layer7_out_0_V=128 (0.125) with vld=1; no vld during or immediately after reset.
- x0=2.0, x1=1.0 (input_2_V=0x010000800) → output 1408 (1.375).
- x0=−1.0 (raw 0x3FC00), x1=0 → output 384 (0.375).
- x0=x1=0x1FFFF → h0 saturates to 131071, h3=130047 → output −64384 (0x30480).
- Back-to-back three samples (zero, (2,1), (−1,0)) on consecutive cycles → 128, 1408, 384 on three consecutive cycles. Dropping vld for one cycle in the middle produces a one-cycle gap in the output valid.
- Assert ap_rst for one cycle while two samples are in flight → neither result appears. ap_start low with an empty pipeline → ap_idle=1, ap_ready=0.
